// File: rtl/julia_pkg.sv
// Shared types and constants for the Julia-set escape-time engine.
package julia_pkg;

  localparam int DEF_DATA_W = 18;
  localparam int DEF_FRAC_W = 14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAP  = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef logic signed [DEF_DATA_W-1:0] fx_t;

  // |z|^2 threshold (4.0) for a given number of fractional bits
  function automatic int esc_limit(input int frac_w);
    return 4 << frac_w;
  endfunction

  localparam int ESC_LIMIT = esc_limit(DEF_FRAC_W);

endpackage

// File: rtl/julia_step.sv
// One z <- z^2 + c iteration plus the |z|^2 > 4.0 escape test, combinational.
module julia_step
  import julia_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAC_W = DEF_FRAC_W
) (
  input  logic signed [DATA_W-1:0] i_z_re,
  input  logic signed [DATA_W-1:0] i_z_im,
  input  logic signed [DATA_W-1:0] i_c_re,
  input  logic signed [DATA_W-1:0] i_c_im,
  output logic signed [DATA_W-1:0] o_z_re_nxt,
  output logic signed [DATA_W-1:0] o_z_im_nxt,
  output logic                     o_escape
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int PW     = PROD_W - FRAC_W;
  localparam logic signed [PW:0] LIM = (PW+1)'(esc_limit(FRAC_W));

  logic signed [PROD_W-1:0] w_zr_ext, w_zi_ext;
  logic signed [PROD_W-1:0] w_p_rr, w_p_ii, w_p_ri;
  logic signed [PW-1:0]     w_sq_re, w_sq_im, w_cross;
  logic signed [PW:0]       w_mag;
  logic                     w_unused;

  assign w_zr_ext = {{DATA_W{i_z_re[DATA_W-1]}}, i_z_re};
  assign w_zi_ext = {{DATA_W{i_z_im[DATA_W-1]}}, i_z_im};

  assign w_p_rr = w_zr_ext * w_zr_ext;
  assign w_p_ii = w_zi_ext * w_zi_ext;
  assign w_p_ri = w_zr_ext * w_zi_ext;

  // Arithmetic shift right by FRAC_W, keeping PW bits
  assign w_sq_re = w_p_rr[PROD_W-1:FRAC_W];
  assign w_sq_im = w_p_ii[PROD_W-1:FRAC_W];
  assign w_cross = w_p_ri[PROD_W-1:FRAC_W];

  // One guard bit so the sum of two squares never wraps
  assign w_mag    = {w_sq_re[PW-1], w_sq_re} + {w_sq_im[PW-1], w_sq_im};
  assign o_escape = (w_mag > LIM);

  // Next z only needs the low DATA_W bits (two's-complement wrap)
  assign o_z_re_nxt = w_sq_re[DATA_W-1:0] - w_sq_im[DATA_W-1:0] + i_c_re;
  assign o_z_im_nxt = {w_cross[DATA_W-2:0], 1'b0} + i_c_im;

  // Fraction bits below the binary point and cross-product bits above the
  // wrap width are dropped on purpose
  assign w_unused = ^{w_p_rr[FRAC_W-1:0], w_p_ii[FRAC_W-1:0],
                      w_p_ri[FRAC_W-1:0], w_cross[PW-1:DATA_W-1]};

endmodule

// File: rtl/julia_iter.sv
// Escape-time engine: maps a pixel to z0, iterates z^2 + c, reports the count.
module julia_iter
  import julia_pkg::*;
#(
  parameter int PIX_W  = 10,
  parameter int DATA_W = 18,
  parameter int FRAC_W = 14,
  parameter int ITER_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     pix_valid,
  output logic                     pix_ready,
  input  logic [PIX_W-1:0]         pix_x,
  input  logic [PIX_W-1:0]         pix_y,
  input  logic signed [DATA_W-1:0] c_re,
  input  logic signed [DATA_W-1:0] c_im,
  input  logic signed [DATA_W-1:0] x_start,
  input  logic signed [DATA_W-1:0] y_start,
  input  logic signed [DATA_W-1:0] step,
  input  logic [ITER_W-1:0]        max_iter,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PIX_W-1:0]         out_x,
  output logic [PIX_W-1:0]         out_y,
  output logic [ITER_W-1:0]        out_iter,
  output logic                     out_escaped
);

  state_t                   r_state;
  logic                     r_pix_ready;
  logic                     r_out_valid;
  logic [PIX_W-1:0]         r_out_x, r_out_y;
  logic [ITER_W-1:0]        r_out_iter;
  logic                     r_out_esc;

  logic [PIX_W-1:0]         r_x, r_y;
  logic signed [DATA_W-1:0] r_cre, r_cim, r_xs, r_ys, r_step;
  logic [ITER_W-1:0]        r_max;
  logic signed [DATA_W-1:0] r_zre, r_zim;
  logic [ITER_W-1:0]        r_n;

  logic [DATA_W-1:0]        w_xu, w_yu;
  logic signed [DATA_W-1:0] w_xoff, w_yoff;
  logic signed [DATA_W-1:0] w_zre_nxt, w_zim_nxt;
  logic                     w_escape;

  // Pixel -> complex plane: zero-extended coordinate times step, wrapped
  assign w_xu   = {{(DATA_W-PIX_W){1'b0}}, r_x};
  assign w_yu   = {{(DATA_W-PIX_W){1'b0}}, r_y};
  assign w_xoff = $signed(w_xu) * r_step;
  assign w_yoff = $signed(w_yu) * r_step;

  julia_step #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_step (
    .i_z_re     (r_zre),
    .i_z_im     (r_zim),
    .i_c_re     (r_cre),
    .i_c_im     (r_cim),
    .o_z_re_nxt (w_zre_nxt),
    .o_z_im_nxt (w_zim_nxt),
    .o_escape   (w_escape)
  );

  // Control FSM with capture, iteration and registered result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pix_ready <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_x     <= '0;
      r_out_y     <= '0;
      r_out_iter  <= '0;
      r_out_esc   <= 1'b0;
      r_zre       <= '0;
      r_zim       <= '0;
      r_n         <= '0;
    end else if (clear) begin
      r_state     <= IDLE;
      r_pix_ready <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_pix_ready && pix_valid) begin
            r_x         <= pix_x;
            r_y         <= pix_y;
            r_cre       <= c_re;
            r_cim       <= c_im;
            r_xs        <= x_start;
            r_ys        <= y_start;
            r_step      <= step;
            r_max       <= max_iter;
            r_pix_ready <= 1'b0;
            r_state     <= MAP;
          end else begin
            r_pix_ready <= 1'b1;
          end
        end
        MAP: begin
          r_zre   <= r_xs + w_xoff;
          r_zim   <= r_ys - w_yoff;
          r_n     <= '0;
          r_state <= ITER;
        end
        ITER: begin
          if (w_escape || (r_n == r_max)) begin
            r_out_esc   <= w_escape;
            r_out_iter  <= r_n;
            r_out_x     <= r_x;
            r_out_y     <= r_y;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_zre <= w_zre_nxt;
            r_zim <= w_zim_nxt;
            r_n   <= r_n + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_pix_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign pix_ready   = r_pix_ready;
  assign out_valid   = r_out_valid;
  assign out_x       = r_out_x;
  assign out_y       = r_out_y;
  assign out_iter    = r_out_iter;
  assign out_escaped = r_out_esc;

endmodule

// File: tb/tb_julia_iter.sv
// Randomized and directed bench for julia_iter against an arithmetic model.
module tb_julia_iter;

  localparam int PIX_W  = 10;
  localparam int DATA_W = 18;
  localparam int FRAC_W = 14;
  localparam int ITER_W = 8;

  logic                     clk = 1'b0;
  logic                     rst, clear, pix_valid, pix_ready;
  logic [PIX_W-1:0]         pix_x, pix_y;
  logic signed [DATA_W-1:0] c_re, c_im, x_start, y_start, step;
  logic [ITER_W-1:0]        max_iter;
  logic                     out_valid, out_ready, out_escaped;
  logic [PIX_W-1:0]         out_x, out_y;
  logic [ITER_W-1:0]        out_iter;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  julia_iter #(
    .PIX_W (PIX_W), .DATA_W (DATA_W), .FRAC_W (FRAC_W), .ITER_W (ITER_W)
  ) dut (
    .clk (clk), .rst (rst), .clear (clear),
    .pix_valid (pix_valid), .pix_ready (pix_ready),
    .pix_x (pix_x), .pix_y (pix_y),
    .c_re (c_re), .c_im (c_im),
    .x_start (x_start), .y_start (y_start), .step (step),
    .max_iter (max_iter),
    .out_valid (out_valid), .out_ready (out_ready),
    .out_x (out_x), .out_y (out_y),
    .out_iter (out_iter), .out_escaped (out_escaped)
  );

  task automatic check(input string tag, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Two's-complement wrap to DATA_W bits
  function automatic longint wrap(input longint v);
    longint m;
    m = v & ((longint'(1) << DATA_W) - 1);
    if (m >= (longint'(1) << (DATA_W-1))) m = m - (longint'(1) << DATA_W);
    return m;
  endfunction

  // Escape-time reference: map pixel, then iterate until |z|^2 > 4 or limit
  function automatic void ref_model(input int x, input int y,
                                    input longint cre, input longint cim,
                                    input longint xs, input longint ys,
                                    input longint stp, input int mx,
                                    output int n, output bit esc);
    longint zr, zi, sr, si, cr;
    zr  = wrap(xs + longint'(x) * stp);
    zi  = wrap(ys - longint'(y) * stp);
    n   = 0;
    esc = 1'b0;
    for (int k = 0; k <= mx; k++) begin
      n  = k;
      sr = (zr * zr) >>> FRAC_W;
      si = (zi * zi) >>> FRAC_W;
      cr = (zr * zi) >>> FRAC_W;
      if (sr + si > (longint'(4) << FRAC_W)) begin
        esc = 1'b1;
        return;
      end
      if (k == mx) return;
      zr = wrap(sr - si + cre);
      zi = wrap(2 * cr + cim);
    end
  endfunction

  task automatic start_pixel(input int x, input int y,
                             input longint cre, input longint cim,
                             input longint xs, input longint ys,
                             input longint stp, input int mx);
    int cyc;
    cyc = 0;
    while (!pix_ready && cyc < 20) begin
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    check("pix_ready_idle", longint'(pix_ready), 1);
    pix_x     = PIX_W'(x);
    pix_y     = PIX_W'(y);
    c_re      = DATA_W'(cre);
    c_im      = DATA_W'(cim);
    x_start   = DATA_W'(xs);
    y_start   = DATA_W'(ys);
    step      = DATA_W'(stp);
    max_iter  = ITER_W'(mx);
    pix_valid = 1'b1;
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    // Later config changes must not disturb the captured pixel
    pix_x    = PIX_W'($urandom);
    pix_y    = PIX_W'($urandom);
    c_re     = DATA_W'($urandom);
    c_im     = DATA_W'($urandom);
    x_start  = DATA_W'($urandom);
    y_start  = DATA_W'($urandom);
    step     = DATA_W'($urandom);
    max_iter = ITER_W'($urandom);
  endtask

  task automatic run_pixel(input int x, input int y,
                           input longint cre, input longint cim,
                           input longint xs, input longint ys,
                           input longint stp, input int mx, input int hold,
                           output int got_n, output int got_esc);
    int exp_n, cyc;
    bit exp_esc, seen;
    ref_model(x, y, cre, cim, xs, ys, stp, mx, exp_n, exp_esc);
    start_pixel(x, y, cre, cim, xs, ys, stp, mx);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < mx + 20) begin
      @(posedge clk); @(negedge clk);
      cyc++;
      seen = out_valid;
    end
    check("latency", cyc, exp_n + 2);
    got_n   = -1;
    got_esc = -1;
    if (!seen) return;
    check("out_x", longint'(out_x), x);
    check("out_y", longint'(out_y), y);
    check("out_iter", longint'(out_iter), exp_n);
    check("out_escaped", longint'(out_escaped), longint'(exp_esc));
    check("pix_ready_done", longint'(pix_ready), 0);
    got_n   = int'(out_iter);
    got_esc = int'(out_escaped);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); @(negedge clk);
      check("hold_valid", longint'(out_valid), 1);
      check("hold_iter", longint'(out_iter), exp_n);
      check("hold_x", longint'(out_x), x);
      check("hold_ready", longint'(pix_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("valid_after_hs", longint'(out_valid), 0);
    check("ready_after_hs", longint'(pix_ready), 1);
  endtask

  // Watch a window of cycles and report whether out_valid ever rose
  task automatic watch_no_valid(input string tag, input int ncyc);
    bit any;
    any = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk); @(negedge clk);
      if (out_valid) any = 1'b1;
    end
    check(tag, longint'(any), 0);
  endtask

  initial begin
    int n, e;
    rst = 1'b1; clear = 1'b0; pix_valid = 1'b0; out_ready = 1'b0;
    pix_x = '0; pix_y = '0; c_re = '0; c_im = '0;
    x_start = '0; y_start = '0; step = '0; max_iter = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_iter", longint'(out_iter), 0);
    check("rst_out_x", longint'(out_x), 0);
    check("rst_out_y", longint'(out_y), 0);
    check("rst_out_esc", longint'(out_escaped), 0);
    check("rst_pix_ready", longint'(pix_ready), 0);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check("idle_pix_ready", longint'(pix_ready), 1);

    // Directed cases with hand-derived results
    run_pixel(0, 0, 0, 0, 40960, 0, 0, 20, 0, n, e);
    check("early_iter", n, 0);
    check("early_esc", e, 1);
    run_pixel(0, 0, 0, 0, 24576, 0, 0, 20, 5, n, e);
    check("one_iter", n, 1);
    check("one_esc", e, 1);
    run_pixel(0, 0, 0, 0, 32768, 0, 0, 20, 0, n, e);
    check("bound_iter", n, 1);
    check("bound_esc", e, 1);
    run_pixel(3, 0, 0, 0, -32768, 0, 4096, 20, 1, n, e);
    check("map_iter", n, 2);
    check("map_esc", e, 1);
    run_pixel(0, 0, 0, 0, 0, 0, 0, 20, 0, n, e);
    check("limit_iter", n, 20);
    check("limit_esc", e, 0);
    run_pixel(0, 0, 0, 0, 0, 0, 0, 0, 0, n, e);
    check("max0_iter", n, 0);
    check("max0_esc", e, 0);
    run_pixel(0, 0, 0, 0, 40960, 0, 0, 0, 0, n, e);
    check("max0_esc_iter", n, 0);
    check("max0_esc_esc", e, 1);

    // Abort by clear mid-iteration
    start_pixel(1, 2, 0, 0, 0, 0, 0, 50);
    repeat (6) @(posedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    @(negedge clk);
    check("clear_valid", longint'(out_valid), 0);
    check("clear_ready", longint'(pix_ready), 1);
    watch_no_valid("clear_no_result", 60);
    run_pixel(5, 7, -8192, 4915, -32768, 16384, 1000, 30, 0, n, e);

    // Abort by reset mid-iteration
    start_pixel(9, 4, 0, 0, 0, 0, 0, 50);
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst2_valid", longint'(out_valid), 0);
    check("rst2_iter", longint'(out_iter), 0);
    check("rst2_x", longint'(out_x), 0);
    check("rst2_y", longint'(out_y), 0);
    check("rst2_ready", longint'(pix_ready), 0);
    @(posedge clk); @(negedge clk);
    check("rst2_ready_idle", longint'(pix_ready), 1);
    watch_no_valid("rst_no_result", 60);
    run_pixel(11, 3, 3000, -6000, -20000, 20000, 700, 25, 0, n, e);

    // Randomized pixels and configurations
    for (int t = 0; t < 40; t++) begin
      run_pixel(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                longint'($urandom_range(0, 32768)) - 16384,
                longint'($urandom_range(0, 32768)) - 16384,
                longint'($urandom_range(0, 80000)) - 40000,
                longint'($urandom_range(0, 80000)) - 40000,
                longint'($urandom_range(0, 1200)) - 600,
                int'($urandom_range(0, 40)), int'($urandom_range(0, 2)), n, e);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
